// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the mm:ss countdown timer.
// COUNTDOWN_BUZZER_EN (see countdown_timer.sv) enables the buzzer.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LIM9 = 4'd9;
    localparam logic [3:0] LIM5 = 4'd5;

    localparam int BUZZ_TICKS = 5;
    localparam int BUZZ_W     = $clog2(BUZZ_TICKS + 1);

    function automatic logic [3:0] clamp(
        input logic [3:0] d,
        input logic [3:0] lim
    );
        return (d > lim) ? lim : d;
    endfunction

endpackage

// File: rtl/countdown_timer_digit.sv
// One BCD digit counting down from limit to 0 with borrow-out.
// Load clamps the preset to limit; borrow wraps the digit to limit.
module bcd_down_digit
    import countdown_timer_pkg::*;
#(
    parameter logic [3:0] limit = LIM9
) (
    input  logic       clk,
    input  logic       cr,
    input  logic       en,
    input  logic       ld,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       bo
);

    assign bo = en && (q == 4'd0);

    always_ff @(posedge clk) begin
        if (cr) begin
            q <= 4'd0;
        end else if (ld) begin
            q <= clamp(d, limit);
        end else if (en) begin
            q <= (q == 4'd0) ? limit : q - 4'd1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// mm:ss countdown timer, four chained BCD digits plus control FSM.
// Define COUNTDOWN_BUZZER_EN to get a buzzer pulse of BUZZ_TICKS ticks.
module countdown_timer
    import countdown_timer_pkg::*;
(
    input  logic       clk,
    input  logic       cr,
    input  logic       tick,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] ld_mt,
    input  logic [3:0] ld_mu,
    input  logic [3:0] ld_st,
    input  logic [3:0] ld_su,
    output logic [3:0] mt,
    output logic [3:0] mu,
    output logic [3:0] st,
    output logic [3:0] su,
    output logic       busy,
    output logic       bo,
    output logic       bz
);

    state_t state;

    logic nz;
    logic last;
    logic run_tick;
    logic hit_zero;
    logic ld_ok;
    logic su_bo;
    logic st_bo;
    logic mu_bo;
    logic mt_unused_bo;

    assign nz       = |{mt, mu, st, su};
    assign last     = ({mt, mu, st, su} == 16'h0001);
    assign run_tick = (state == RUN) && tick && nz;
    assign hit_zero = (state == RUN) && tick && last;
    assign ld_ok    = load && ((state == IDLE) || (state == DONE));
    assign busy     = (state == RUN) || (state == PAUSE);

    bcd_down_digit #(.limit(LIM9)) u_su (
        .clk (clk),
        .cr  (cr),
        .en  (run_tick),
        .ld  (ld_ok),
        .d   (ld_su),
        .q   (su),
        .bo  (su_bo)
    );

    bcd_down_digit #(.limit(LIM5)) u_st (
        .clk (clk),
        .cr  (cr),
        .en  (su_bo),
        .ld  (ld_ok),
        .d   (ld_st),
        .q   (st),
        .bo  (st_bo)
    );

    bcd_down_digit #(.limit(LIM9)) u_mu (
        .clk (clk),
        .cr  (cr),
        .en  (st_bo),
        .ld  (ld_ok),
        .d   (ld_mu),
        .q   (mu),
        .bo  (mu_bo)
    );

    // Borrow out of the top digit cannot occur: RUN never ticks at 00:00.
    bcd_down_digit #(.limit(LIM9)) u_mt (
        .clk (clk),
        .cr  (cr),
        .en  (mu_bo),
        .ld  (ld_ok),
        .d   (ld_mt),
        .q   (mt),
        .bo  (mt_unused_bo)
    );

    always_ff @(posedge clk) begin
        if (cr) begin
            state <= IDLE;
            bo    <= 1'b0;
        end else begin
            bo <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (load) begin
                        state <= IDLE;
                    end else if (start) begin
                        state <= nz ? RUN : IDLE;
                    end
                end
                RUN: begin
                    if (hit_zero) begin
                        state <= DONE;
                        bo    <= 1'b1;
                    end else if (pause) begin
                        state <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (start && !pause) begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef COUNTDOWN_BUZZER_EN
    logic [BUZZ_W-1:0] bcnt;
    logic              bz_q;

    assign bz = bz_q;

    always_ff @(posedge clk) begin
        if (cr) begin
            bz_q <= 1'b0;
            bcnt <= '0;
        end else if (hit_zero) begin
            bz_q <= 1'b1;
            bcnt <= '0;
        end else if (load || start) begin
            bz_q <= 1'b0;
            bcnt <= '0;
        end else if (bz_q && tick) begin
            if (bcnt == BUZZ_W'(BUZZ_TICKS - 1)) begin
                bz_q <= 1'b0;
                bcnt <= '0;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end
`else
    assign bz = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random stimulus
// against a seconds-based reference model (honours COUNTDOWN_BUZZER_EN).
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       cr;
    logic       tick;
    logic       load;
    logic       start;
    logic       pause;
    logic [3:0] ld_mt;
    logic [3:0] ld_mu;
    logic [3:0] ld_st;
    logic [3:0] ld_su;
    logic [3:0] mt;
    logic [3:0] mu;
    logic [3:0] st;
    logic [3:0] su;
    logic       busy;
    logic       bo;
    logic       bz;

    always #5 clk = ~clk;

    countdown_timer dut (
        .clk   (clk),
        .cr    (cr),
        .tick  (tick),
        .load  (load),
        .start (start),
        .pause (pause),
        .ld_mt (ld_mt),
        .ld_mu (ld_mu),
        .ld_st (ld_st),
        .ld_su (ld_su),
        .mt    (mt),
        .mu    (mu),
        .st    (st),
        .su    (su),
        .busy  (busy),
        .bo    (bo),
        .bz    (bz)
    );

    int n_vec = 0;
    int n_bad = 0;
    int bo_seen = 0;

    // model: 0 idle, 1 run, 2 pause, 3 done; count kept as plain seconds
    int m_st = 0;
    int secs = 0;
    int m_bcnt = 0;
    bit m_bo = 1'b0;
    bit m_bz = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic int clampd(input int d, input int lim);
        return (d > lim) ? lim : d;
    endfunction

    task automatic model_edge();
        bit hit;
        hit = 1'b0;
        if (cr) begin
            m_st = 0; secs = 0; m_bo = 0; m_bz = 0; m_bcnt = 0;
            return;
        end
        m_bo = 1'b0;
        case (m_st)
            0, 3: begin
                if (load) begin
                    secs = clampd(ld_mt, 9) * 600 + clampd(ld_mu, 9) * 60
                         + clampd(ld_st, 5) * 10 + clampd(ld_su, 9);
                    m_st = 0;
                end else if (start) begin
                    m_st = (secs > 0) ? 1 : 0;
                end
            end
            1: begin
                if (tick && secs > 0) begin
                    secs--;
                    if (secs == 0) begin
                        m_st = 3; hit = 1'b1; m_bo = 1'b1;
                    end
                end
                if (!hit && pause) m_st = 2;
            end
            2: if (start && !pause) m_st = 1;
            default: m_st = 0;
        endcase
`ifdef COUNTDOWN_BUZZER_EN
        if (hit) begin
            m_bz = 1'b1; m_bcnt = 0;
        end else if (load || start) begin
            m_bz = 1'b0; m_bcnt = 0;
        end else if (m_bz && tick) begin
            m_bcnt++;
            if (m_bcnt == 5) begin
                m_bz = 1'b0; m_bcnt = 0;
            end
        end
`endif
    endtask

    task automatic cmp_all();
        check("mt", {28'd0, mt}, secs / 600);
        check("mu", {28'd0, mu}, (secs / 60) % 10);
        check("st", {28'd0, st}, (secs % 60) / 10);
        check("su", {28'd0, su}, secs % 10);
        check("busy", {31'd0, busy}, (m_st == 1 || m_st == 2) ? 1 : 0);
        check("bo", {31'd0, bo}, {31'd0, m_bo});
        check("bz", {31'd0, bz}, {31'd0, m_bz});
        if (bo === 1'b1) bo_seen++;
    endtask

    task automatic step(input bit c, input bit t, input bit l,
                        input bit s, input bit p);
        cr = c; tick = t; load = l; start = s; pause = p;
        @(posedge clk);
        model_edge();
        #1;
        cmp_all();
    endtask

    task automatic preset(input int a, input int b, input int c, input int d);
        ld_mt = 4'(a); ld_mu = 4'(b); ld_st = 4'(c); ld_su = 4'(d);
    endtask

    initial begin
        cr = 1'b1; tick = 0; load = 0; start = 0; pause = 0;
        preset(0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("rst_digits", {16'd0, mt, mu, st, su}, 32'h0000);
        check("rst_busy", {31'd0, busy}, 0);

        // 01:05 runs to zero in 65 ticks
        preset(0, 1, 0, 5);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        check("run_busy", {31'd0, busy}, 1);
        bo_seen = 0;
        repeat (65) step(0, 1, 0, 0, 0);
        check("d1_zero", {16'd0, mt, mu, st, su}, 32'h0000);
        check("d1_busy", {31'd0, busy}, 0);
        step(0, 0, 0, 0, 0);
        check("d1_bo_cnt", bo_seen, 1);

        // 10:00 -> 09:59
        preset(1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        check("d2_0959", {16'd0, mt, mu, st, su}, 32'h0959);

        // pause on 2nd tick, hold, resume
        step(1, 0, 0, 0, 0);
        preset(0, 0, 0, 3);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        repeat (10) step(0, 1, 0, 0, 0);
        check("d3_hold", {16'd0, mt, mu, st, su}, 32'h0001);
        step(0, 1, 0, 1, 1);
        check("d3_pwins", {31'd0, busy}, 1);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        check("d3_zero", {16'd0, mt, mu, st, su}, 32'h0000);
        check("d3_bo", {31'd0, bo}, 1);
        step(0, 0, 0, 0, 0);
        check("d3_bo_off", {31'd0, bo}, 0);

        // clamping, load ignored in RUN, zero start stays idle
        preset(0, 0, 7, 12);
        step(0, 0, 1, 0, 0);
        check("d4_clamp", {16'd0, mt, mu, st, su}, 32'h0059);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        preset(4, 4, 4, 4);
        step(0, 0, 1, 0, 0);
        check("d4_ldrun", {16'd0, mt, mu, st, su}, 32'h0058);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        check("d4_zstart", {31'd0, busy}, 0);

        // reset with tick at 00:01
        bo_seen = 0;
        preset(0, 0, 0, 2);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        check("d5_zero", {16'd0, mt, mu, st, su}, 32'h0000);
        step(0, 1, 0, 0, 0);
        check("d5_nobo", bo_seen, 0);

        // buzzer
        preset(0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
`ifdef COUNTDOWN_BUZZER_EN
        check("d6_bz_on", {31'd0, bz}, 1);
        repeat (4) step(0, 1, 0, 0, 0);
        check("d6_bz_4", {31'd0, bz}, 1);
        step(0, 1, 0, 0, 0);
        check("d6_bz_off", {31'd0, bz}, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        check("d6_bz_ld", {31'd0, bz}, 0);
`else
        check("d6_bz_tied", {31'd0, bz}, 0);
        repeat (6) step(0, 1, 0, 0, 0);
        check("d6_bz_tied2", {31'd0, bz}, 0);
`endif

        // random phase
        for (int i = 0; i < 4000; i++) begin
            ld_mt = ($urandom % 4 == 0) ? 4'($urandom % 16) : 4'd0;
            ld_mu = ($urandom % 3 == 0) ? 4'($urandom % 16) : 4'd0;
            ld_st = 4'($urandom % 16);
            ld_su = 4'($urandom % 16);
            step(($urandom % 300) == 0, ($urandom % 3) != 0,
                 ($urandom % 20) == 0, ($urandom % 8) == 0,
                 ($urandom % 15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock port clk, reset port cr.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  system clock
- cr  in  1  synchronous active-high clear
- tick  in  1  one-cycle count enable, nominally 1 Hz
- load  in  1  load preset digits
- start  in  1  start or resume counting
- pause  in  1  suspend counting
- ld_mt, ld_mu, ld_st, ld_su  in  4 each  preset digits: minute tens, minute units, second tens, second units (BCD)
- mt, mu, st, su  out  4 each  current digits (BCD)
- busy  out  1  high in RUN or PAUSE
- bo  out  1  one-cycle borrow-out pulse on reaching 00:00
- bz  out  1  buzzer drive (see Configuration)

Function
REQ-003 The FSM SHALL have four states: IDLE, RUN, PAUSE, DONE.
REQ-004 In IDLE or DONE, load SHALL copy the preset digits into the counter at the next clk edge and move to IDLE.
- Digits above their limit SHALL be clamped: mt, mu, su to 9; st to 5.
REQ-005 load SHALL be ignored in RUN and PAUSE.
REQ-006 start in IDLE SHALL move to RUN only if the count is non-zero; with a zero count the block SHALL stay in IDLE.
REQ-007 In RUN, each tick SHALL decrement the count by one second as a borrow chain:
- su 9..0, then st 5..0, then mu 9..0, then mt 9..0.
- Example: 10:00 -> 09:59.
REQ-008 The decrement from 00:01 to 00:00 SHALL move the FSM to DONE on that same edge, and bo SHALL be high for exactly the following cycle.
REQ-009 pause in RUN SHALL move to PAUSE. A tick in the same cycle SHALL still be applied.
REQ-010 start in PAUSE SHALL return to RUN. If start and pause are asserted together, pause SHALL win.
REQ-011 In PAUSE, IDLE and DONE, the digits SHALL hold, and tick SHALL have no effect.
REQ-012 The counter SHALL never wrap below 00:00. The maximum count SHALL be 99:59.
REQ-013 busy SHALL be combinational from state: high in RUN or PAUSE.
REQ-014 start in DONE SHALL be treated as in IDLE, so a zero count stays in IDLE.

Reset
REQ-015 cr high at a clk edge SHALL force all of the following, overriding every other input:
- state IDLE
- all digits 0
- bo 0, bz 0
- internal buzzer tick counter 0
REQ-016 Reset asserted mid-RUN SHALL produce no bo pulse.

Configuration
REQ-017 The macro COUNTDOWN_BUZZER_EN SHALL select the buzzer behaviour.
- Defined: bz SHALL go high on entry to DONE and stay high for BUZZ_TICKS ticks (package constant, 5). Any load or start SHALL clear it early.
- Undefined: bz SHALL be tied 0 and no buzzer counter SHALL be synthesized.

Structure
REQ-018 A shared package SHALL hold:
- state encoding constants
- digit limits (9, 5)
- BUZZ_TICKS
REQ-019 The digit SHALL be a sub-module bcd_down_digit, instantiated four times with a borrow chain.
- Parameter: limit.
- Ports: clk, cr, en, ld, d, q, bo.
- bo SHALL be high when q==0 and en is high.
- On en with q==0, q SHALL reload to limit.

Verification
REQ-020 The bench SHALL cover:
- Load 01:05, start, 65 ticks -> digits reach 00:00, one bo pulse, state DONE, busy 0.
- Load 10:00, start, 1 tick -> 09:59.
- Load 00:03, start, pause on the 2nd tick -> 00:01 held through 10 further ticks; start, 1 tick -> 00:00 and bo.
- Load with ld_st=7, ld_su=12 -> st=5, su=9. Load during RUN -> ignored. Start with 00:00 -> stays IDLE.
- cr high mid-RUN at 00:01 together with tick -> digits 00:00, IDLE, bo never asserted.
- With COUNTDOWN_BUZZER_EN: after DONE, bz high for 5 ticks then low; load during buzz -> bz low the next cycle. Without the macro: bz constant 0.
